// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit that owns the HI/LO registers and serves MFHI/MFLO reads.
// Optional feature macro: MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops (codes 9-12).
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        MDU_i_clk,
    input  logic        MDU_i_reset,
    input  logic [31:0] MDU_i_Operand1,
    input  logic [31:0] MDU_i_Operand2,
    input  logic [3:0]  MDU_i_Operation,
    input  logic        MDU_i_Start,
    output logic        MDU_o_Busy,
    output logic [31:0] MDU_o_HI,
    output logic [31:0] MDU_o_LO,
    output logic [31:0] MDU_o_Result
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYCLES - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      op_q, op_d;
    logic [31:0]     a_q, a_d, b_q, b_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;

    logic            launch_op;
    logic            is_div_q;
    logic [CW-1:0]   last_cnt;
    logic [63:0]     prod_s, prod_u;
    logic            a_neg, b_neg;
    logic [31:0]     a_mag, b_mag, b_safe, q_mag, r_mag, q_div, r_div;
    logic [63:0]     res;

    always_comb begin
        launch_op = (MDU_i_Operation == OP_MULT) || (MDU_i_Operation == OP_MULTU) ||
                    (MDU_i_Operation == OP_DIV)  || (MDU_i_Operation == OP_DIVU);
`ifdef MDU_MADD_EN
        launch_op = launch_op || (MDU_i_Operation >= OP_MADD && MDU_i_Operation <= OP_MSUBU);
`endif
    end

    assign is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign last_cnt = is_div_q ? DIV_LAST : MUL_LAST;

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide goes through magnitudes so 0x80000000 / -1 wraps naturally to 0x80000000.
    assign a_neg  = (op_q == OP_DIV) & a_q[31];
    assign b_neg  = (op_q == OP_DIV) & b_q[31];
    assign a_mag  = a_neg ? (~a_q + 32'd1) : a_q;
    assign b_mag  = b_neg ? (~b_q + 32'd1) : b_q;
    assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign q_div  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign r_div  = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        res = {hi_q, lo_q};
        case (op_q)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV, OP_DIVU: begin
                if (b_q == 32'd0) res = {a_q, 32'hFFFF_FFFF};
                else              res = {r_div, q_div};
            end
`ifdef MDU_MADD_EN
            OP_MADD:  res = {hi_q, lo_q} + prod_s;
            OP_MADDU: res = {hi_q, lo_q} + prod_u;
            OP_MSUB:  res = {hi_q, lo_q} - prod_s;
            OP_MSUBU: res = {hi_q, lo_q} - prod_u;
`endif
            default:  res = {hi_q, lo_q};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (MDU_i_Start) begin
                    if (launch_op) begin
                        op_d    = MDU_i_Operation;
                        a_d     = MDU_i_Operand1;
                        b_d     = MDU_i_Operand2;
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end else if (MDU_i_Operation == OP_MTHI) begin
                        hi_d = MDU_i_Operand1;
                    end else if (MDU_i_Operation == OP_MTLO) begin
                        lo_d = MDU_i_Operand1;
                    end
                end
            end
            S_RUN: begin
                // Start is deliberately not looked at here.
                if (cnt_q == last_cnt) begin
                    {hi_d, lo_d} = res;
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge MDU_i_clk or posedge MDU_i_reset) begin
        if (MDU_i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign MDU_o_Busy   = (state_q == S_RUN);
    assign MDU_o_HI     = hi_q;
    assign MDU_o_LO     = lo_q;
    assign MDU_o_Result = (MDU_i_Operation == OP_MFHI) ? hi_q :
                          (MDU_i_Operation == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops against a plain-arithmetic model.
// Follows MDU_MADD_EN so the accumulate ops are expected to work or to act as NOPs.
module tb_mult_div_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk, rst, start, busy;
    logic [31:0] op1, op2, hi, lo, result;
    logic [3:0]  opc;

    int tests = 0;
    int fails = 0;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .MDU_i_clk(clk), .MDU_i_reset(rst), .MDU_i_Operand1(op1), .MDU_i_Operand2(op2),
        .MDU_i_Operation(opc), .MDU_i_Start(start), .MDU_o_Busy(busy), .MDU_o_HI(hi),
        .MDU_o_LO(lo), .MDU_o_Result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: architectural effect of one started op on HI/LO, plus its Busy length.
    task automatic model(input logic [3:0] op, input logic [31:0] a, b,
                         input logic [31:0] hi_in, lo_in,
                         output logic [31:0] hi_o, output logic [31:0] lo_o, output int cyc);
        longint      sa, sb;
        logic [63:0] p, acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi_o = hi_in; lo_o = lo_in; cyc = 0;
        acc = {hi_in, lo_in};
        case (op)
            4'd1: begin p = 64'(sa * sb); {hi_o, lo_o} = p; cyc = MC; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; {hi_o, lo_o} = p; cyc = MC; end
            4'd3: begin
                cyc = DC;
                if (b == 0) begin lo_o = 32'hFFFF_FFFF; hi_o = a; end
                else begin lo_o = 32'(sa / sb); hi_o = 32'(sa % sb); end
            end
            4'd4: begin
                cyc = DC;
                if (b == 0) begin lo_o = 32'hFFFF_FFFF; hi_o = a; end
                else begin lo_o = a / b; hi_o = a % b; end
            end
            4'd7: hi_o = a;
            4'd8: lo_o = a;
`ifdef MDU_MADD_EN
            4'd9:  begin {hi_o, lo_o} = acc + 64'(sa * sb); cyc = MC; end
            4'd10: begin {hi_o, lo_o} = acc + {32'd0, a} * {32'd0, b}; cyc = MC; end
            4'd11: begin {hi_o, lo_o} = acc - 64'(sa * sb); cyc = MC; end
            4'd12: begin {hi_o, lo_o} = acc - {32'd0, a} * {32'd0, b}; cyc = MC; end
`endif
            default: ;
        endcase
    endtask

    // Drives one Start pulse, then reads MFLO while busy and counts Busy cycles (bounded).
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, b,
                         output int cyc, output logic [31:0] mid_lo);
        @(negedge clk);
        opc = op; op1 = a; op2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; opc = 4'd6; op1 = $urandom; op2 = $urandom;
        #1 mid_lo = result;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        opc = 4'd0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; opc = 4'd0; op1 = '0; op2 = '0;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            fails++; $display("FAIL reset_hold: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || result !== 32'd0) begin
            fails++; $display("FAIL reset_release: busy=%b hi=%h lo=%h res=%h", busy, hi, lo, result);
        end
    endtask

    task automatic test_mult();
        int cyc; logic [31:0] mid;
        do_op(4'd1, 32'hFFFF_FFFE, 32'd3, cyc, mid);
        tests++;
        if (cyc != MC || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA || mid !== 32'd0) begin
            fails++; $display("FAIL mult_signed: cyc=%0d hi=%h lo=%h mid=%h, want %0d/ffffffff/fffffffa/0", cyc, hi, lo, mid, MC);
        end
        do_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, mid);
        tests++;
        if (cyc != MC || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || mid !== 32'hFFFF_FFFA) begin
            fails++; $display("FAIL multu: cyc=%0d hi=%h lo=%h mid=%h, want %0d/fffffffe/00000001/fffffffa", cyc, hi, lo, mid, MC);
        end
    endtask

    task automatic test_div();
        int cyc; logic [31:0] mid;
        do_op(4'd3, 32'hFFFF_FFF9, 32'd2, cyc, mid);
        tests++;
        if (cyc != DC || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL div_neg: cyc=%0d hi=%h lo=%h, want %0d/ffffffff/fffffffd", cyc, hi, lo, DC);
        end
        do_op(4'd4, 32'd7, 32'd0, cyc, mid);
        tests++;
        if (cyc != DC || lo !== 32'hFFFF_FFFF || hi !== 32'd7) begin
            fails++; $display("FAIL divu_zero: cyc=%0d hi=%h lo=%h, want %0d/7/ffffffff", cyc, hi, lo, DC);
        end
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc, mid);
        tests++;
        if (cyc != DC || lo !== 32'h8000_0000 || hi !== 32'd0) begin
            fails++; $display("FAIL div_overflow: cyc=%0d hi=%h lo=%h, want %0d/0/80000000", cyc, hi, lo, DC);
        end
        do_op(4'd3, 32'hFFFF_FFF9, 32'd0, cyc, mid);
        tests++;
        if (cyc != DC || lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF9) begin
            fails++; $display("FAIL div_zero: cyc=%0d hi=%h lo=%h, want %0d/fffffff9/ffffffff", cyc, hi, lo, DC);
        end
    endtask

    task automatic test_mthi_mfhi();
        int cyc; logic [31:0] mid;
        do_op(4'd7, 32'h1234, 32'd0, cyc, mid);
        @(negedge clk);
        opc = 4'd5;
        #1;
        tests++;
        if (cyc != 0 || busy !== 1'b0 || result !== 32'h1234 || hi !== 32'h1234) begin
            fails++; $display("FAIL mthi_mfhi: cyc=%0d busy=%b res=%h, want 0/0/1234", cyc, busy, result);
        end
        opc = 4'd0;
        #1;
        tests++;
        if (result !== 32'd0) begin
            fails++; $display("FAIL result_nop: res=%h, want 0", result);
        end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        @(negedge clk);
        opc = 4'd3; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        @(negedge clk); cyc++;
        opc = 4'd7; op1 = 32'hDEAD; start = 1'b1;
        @(negedge clk); cyc++;
        opc = 4'd2; op1 = 32'd9; op2 = 32'd9;
        @(negedge clk); cyc++;
        start = 1'b0; opc = 4'd0;
        #1;
        while (busy === 1'b1 && cyc < 200) begin
            @(negedge clk); #1;
            if (busy === 1'b1) cyc++;
        end
        tests++;
        if (cyc != DC || lo !== 32'd14 || hi !== 32'd2) begin
            fails++; $display("FAIL start_while_busy: cyc=%0d hi=%h lo=%h, want %0d/2/14", cyc, hi, lo, DC);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || lo !== 32'd14 || hi !== 32'd2) begin
            fails++; $display("FAIL busy_ignored_later: busy=%b hi=%h lo=%h", busy, hi, lo);
        end
    endtask

    task automatic test_async_reset_mid();
        int cyc; logic [31:0] mid;
        do_op(4'd8, 32'h5555, 32'd0, cyc, mid);
        @(negedge clk);
        opc = 4'd3; op1 = 32'd50; op2 = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; opc = 4'd0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            fails++; $display("FAIL async_reset: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
        end
        #1 rst = 1'b0;
        repeat (DC + 4) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            fails++; $display("FAIL reset_discard: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
        end
    endtask

    task automatic test_madd();
        int cyc; logic [31:0] mid, ehi, elo; int ecyc;
        do_op(4'd7, 32'd0, 32'd0, cyc, mid);
        do_op(4'd8, 32'd5, 32'd0, cyc, mid);
        model(4'd9, 32'd2, 32'd3, 32'd0, 32'd5, ehi, elo, ecyc);
        do_op(4'd9, 32'd2, 32'd3, cyc, mid);
`ifdef MDU_MADD_EN
        tests++;
        if (ecyc != MC || elo !== 32'd11 || ehi !== 32'd0) begin
            fails++; $display("FAIL madd_model: cyc=%0d hi=%h lo=%h", ecyc, ehi, elo);
        end
`else
        tests++;
        if (ecyc != 0 || elo !== 32'd5 || ehi !== 32'd0) begin
            fails++; $display("FAIL madd_model_nop: cyc=%0d hi=%h lo=%h", ecyc, ehi, elo);
        end
`endif
        tests++;
        if (cyc != ecyc || hi !== ehi || lo !== elo) begin
            fails++; $display("FAIL madd: cyc=%0d hi=%h lo=%h, want %0d/%h/%h", cyc, hi, lo, ecyc, ehi, elo);
        end
    endtask

    task automatic test_random();
        logic [3:0]  ops [$];
        logic [3:0]  op;
        logic [31:0] a, b, ehi, elo, mid, hi0, lo0;
        int cyc, ecyc;
        ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd0, 4'd5, 4'd13, 4'd9, 4'd10, 4'd11, 4'd12};
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, ops.size() - 1)];
            a = pick(); b = pick();
            hi0 = hi; lo0 = lo;
            model(op, a, b, hi0, lo0, ehi, elo, ecyc);
            do_op(op, a, b, cyc, mid);
            tests++;
            if (cyc != ecyc || hi !== ehi || lo !== elo ||
                mid !== ((ecyc == 0) ? elo : lo0)) begin
                fails++;
                $display("FAIL rand[%0d] op=%0d a=%h b=%h: cyc=%0d hi=%h lo=%h mid=%h, want %0d/%h/%h/%h",
                         i, op, a, b, cyc, hi, lo, mid, ecyc, ehi, elo, (ecyc == 0) ? elo : lo0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mfhi();
        test_start_while_busy();
        test_async_reset_mid();
        test_madd();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
